// File: rtl/countdown_timer_pkg.sv
// countdown_timer shared types and constants.
// Holds the FSM encoding, value limits and input clamp helpers.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 99;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MIN_W   = 7;

  function automatic int presc_w(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  function automatic logic [MIN_W-1:0] clamp_min(
    input logic [MIN_W-1:0] v
  );
    return (v > MIN_W'(MIN_MAX)) ? MIN_W'(MIN_MAX) : v;
  endfunction

  function automatic logic [SEC_W-1:0] clamp_sec(
    input logic [SEC_W-1:0] v
  );
    return (v > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : v;
  endfunction

endpackage

// File: rtl/countdown_timer_down_counter.sv
// Loadable modulo down-counter: wraps from 0 to MAX.
// o_borrow flags a zero count so the next stage can borrow.
module down_counter #(
  parameter int unsigned N   = 6,
  parameter int unsigned MAX = 59
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [N-1:0] i_val,
  output logic [N-1:0] o_count,
  output logic         o_borrow
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_val;
    end else if (i_en) begin
      count_d = (count_q == '0) ? N'(MAX)
                                : count_q - N'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count  = count_q;
  assign o_borrow = (count_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with a 1 Hz prescaler.
// Pulses o_done once and holds o_expired when it reaches 00:00.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [MIN_W-1:0] i_load_min,
  input  logic [SEC_W-1:0] i_load_sec,
  input  logic             i_start,
  input  logic             i_pause,
  output logic [MIN_W-1:0] o_min,
  output logic [SEC_W-1:0] o_sec,
  output logic             o_running,
  output logic             o_expired,
  output logic             o_done
);

  localparam int PRESC_W = presc_w(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST =
    PRESC_W'(TICK_DIV - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               done_q, done_d;
  logic               ld;
  logic               tick;
  logic               last_sec;
  logic               nonzero;
  logic [SEC_W-1:0]   sec_cnt;
  logic [MIN_W-1:0]   min_cnt;
  logic               sec_bor;
  logic               min_bor;

  assign tick     = (state_q == ST_RUNNING) &&
                    (presc_q == PRESC_LAST);
  assign last_sec = tick && min_bor &&
                    (sec_cnt == SEC_W'(1));
  assign nonzero  = !(sec_bor && min_bor);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    if (i_load && state_q != ST_RUNNING) begin
      ld      = 1'b1;
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start && nonzero) begin
            state_d = ST_RUNNING;
            presc_d = '0;
          end
        end
        ST_PAUSED: begin
          if (i_start && nonzero) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          presc_d = tick ? '0 : presc_q + PRESC_W'(1);
          // Expiry wins over a pause landing on the final tick.
          if (last_sec) begin
            state_d = ST_EXPIRED;
            done_d  = 1'b1;
          end else if (i_pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_EXPIRED: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  down_counter #(
    .N   (SEC_W),
    .MAX (SEC_MAX)
  ) u_sec (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (tick),
    .i_load   (ld),
    .i_val    (clamp_sec(i_load_sec)),
    .o_count  (sec_cnt),
    .o_borrow (sec_bor)
  );

  down_counter #(
    .N   (MIN_W),
    .MAX (MIN_MAX)
  ) u_min (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (tick && sec_bor),
    .i_load   (ld),
    .i_val    (clamp_min(i_load_min)),
    .o_count  (min_cnt),
    .o_borrow (min_bor)
  );

  assign o_min     = min_cnt;
  assign o_sec     = sec_cnt;
  assign o_running = (state_q == ST_RUNNING);
  assign o_expired = (state_q == ST_EXPIRED);
  assign o_done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with TICK_DIV=4.
// Expectations are queued with a due cycle and checked on negedge.
module tb_countdown_timer;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [6:0] lmin;
  logic [5:0] lsec;
  logic       start;
  logic       pause;
  logic [6:0] omin;
  logic [5:0] osec;
  logic       orun;
  logic       oexp;
  logic       odone;

  always #5 clk = ~clk;

  countdown_timer #(
    .TICK_DIV (TD)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (load),
    .i_load_min (lmin),
    .i_load_sec (lsec),
    .i_start    (start),
    .i_pause    (pause),
    .o_min      (omin),
    .o_sec      (osec),
    .o_running  (orun),
    .o_expired  (oexp),
    .o_done     (odone)
  );

  typedef struct {
    string       tag;
    int unsigned at;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int          n_run  = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pk(
    input int m, input int s,
    input bit r, input bit e, input bit d
  );
    return {7'(m), 6'(s), r, e, d};
  endfunction

  task automatic check(
    input string tag,
    input logic [15:0] obs,
    input logic [15:0] req
  );
    n_run++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d run%b exp%b done%b, want %0d:%0d run%b exp%b done%b",
        tag, obs[15:9], obs[8:3], obs[2], obs[1], obs[0],
        req[15:9], req[8:3], req[2], req[1], req[0]);
    end
  endtask

  task automatic exp_at(
    input string tag, input int unsigned dt,
    input logic [15:0] v
  );
    exp_t e;
    e.tag = tag;
    e.at  = cyc + dt;
    e.val = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() != 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      check(e.tag, {omin, osec, orun, oexp, odone}, e.val);
    end
  end

  task automatic drive(
    input bit ld, input int m, input int s,
    input bit st, input bit ps
  );
    load  = ld;
    lmin  = 7'(m);
    lsec  = 6'(s);
    start = st;
    pause = ps;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    lmin  = '0;
    lsec  = '0;
    start = 1'b0;
    pause = 1'b0;
    idle(3);
    check("reset_state", {omin, osec, orun, oexp, odone},
          pk(0, 0, 0, 0, 0));
    exp_at("reset_release", 1, pk(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    idle(2);

    // countdown 01:01 with borrow and expiry
    exp_at("ld_0101", 1, pk(1, 1, 0, 0, 0));
    drive(1, 1, 1, 0, 0);
    exp_at("run_0101", 1, pk(1, 1, 1, 0, 0));
    exp_at("tick1", 5, pk(1, 0, 1, 0, 0));
    exp_at("borrow", 9, pk(0, 59, 1, 0, 0));
    exp_at("pre_expire", 244, pk(0, 1, 1, 0, 0));
    exp_at("expire", 245, pk(0, 0, 0, 1, 1));
    exp_at("done_1cyc", 246, pk(0, 0, 0, 1, 0));
    exp_at("exp_sticky", 250, pk(0, 0, 0, 1, 0));
    drive(0, 0, 0, 1, 0);
    idle(250);
    exp_at("start_in_exp", 1, pk(0, 0, 0, 1, 0));
    drive(0, 0, 0, 1, 0);

    // re-arm after expiry
    exp_at("rearm_ld", 1, pk(0, 1, 0, 0, 0));
    drive(1, 0, 1, 0, 0);
    exp_at("rearm_run", 1, pk(0, 1, 1, 0, 0));
    exp_at("rearm_done", 5, pk(0, 0, 0, 1, 1));
    exp_at("rearm_done_lo", 6, pk(0, 0, 0, 1, 0));
    drive(0, 0, 0, 1, 0);
    idle(8);

    // clamping (also leaves EXPIRED)
    exp_at("clamp", 1, pk(99, 59, 0, 0, 0));
    drive(1, 120, 63, 0, 0);

    // start at 00:00 ignored
    exp_at("ld_zero", 1, pk(0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0);
    exp_at("start_zero", 1, pk(0, 0, 0, 0, 0));
    exp_at("start_zero_h", 3, pk(0, 0, 0, 0, 0));
    drive(0, 0, 0, 1, 0);
    idle(3);

    // load while running ignored
    exp_at("ld_0005", 1, pk(0, 5, 0, 0, 0));
    drive(1, 0, 5, 0, 0);
    exp_at("run_0005", 1, pk(0, 5, 1, 0, 0));
    drive(0, 0, 0, 1, 0);
    exp_at("ld_in_run", 1, pk(0, 5, 1, 0, 0));
    drive(1, 0, 30, 0, 0);
    exp_at("pause_0005", 1, pk(0, 5, 0, 0, 0));
    drive(0, 0, 0, 0, 1);

    // pause and resume keep tick phase
    exp_at("ld_0003", 1, pk(0, 3, 0, 0, 0));
    drive(1, 0, 3, 0, 0);
    exp_at("pr_run", 1, pk(0, 3, 1, 0, 0));
    drive(0, 0, 0, 1, 0);
    idle(1);
    exp_at("pr_pause", 1, pk(0, 3, 0, 0, 0));
    drive(0, 0, 0, 0, 1);
    exp_at("pr_hold10", 10, pk(0, 3, 0, 0, 0));
    exp_at("pr_hold20", 20, pk(0, 3, 0, 0, 0));
    idle(20);
    exp_at("pr_resume", 1, pk(0, 3, 1, 0, 0));
    exp_at("pr_no_tick", 2, pk(0, 3, 1, 0, 0));
    exp_at("pr_tick", 3, pk(0, 2, 1, 0, 0));
    drive(0, 0, 0, 1, 0);
    idle(2);
    exp_at("sp_in_run", 1, pk(0, 2, 0, 0, 0));
    drive(0, 0, 0, 1, 1);
    exp_at("sp_in_pause", 1, pk(0, 2, 1, 0, 0));
    drive(0, 0, 0, 1, 1);
    exp_at("pause_again", 1, pk(0, 2, 0, 0, 0));
    drive(0, 0, 0, 0, 1);
    exp_at("ld_st_paused", 1, pk(0, 9, 0, 0, 0));
    exp_at("ld_st_idle", 2, pk(0, 9, 0, 0, 0));
    drive(1, 0, 9, 1, 0);
    idle(2);

    // reset mid-run
    exp_at("ld_0105", 1, pk(1, 5, 0, 0, 0));
    drive(1, 1, 5, 0, 0);
    exp_at("run_0105", 1, pk(1, 5, 1, 0, 0));
    exp_at("mid_run", 10, pk(1, 3, 1, 0, 0));
    drive(0, 0, 0, 1, 0);
    idle(10);
    exp_at("rst_mid", 1, pk(0, 0, 0, 0, 0));
    exp_at("rst_after", 2, pk(0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 100 && sb.size() != 0; i++)
      @(negedge clk);
    check("sb_drain", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
